// File: rtl/dbus_uncached_axi_bridge_pkg.sv
// Shared types and constants for the uncached data-bus to AXI bridge.
package dbus_uncached_axi_bridge_pkg;

  // Bridge FSM: one outstanding transaction, reads and writes on separate paths
  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } dbus_bridge_state_t;

  // CPU size encoding matches the low bits of AXI AxSIZE
  localparam logic [1:0] AXI_SIZE_BYTE = 2'd0;
  localparam logic [1:0] AXI_SIZE_HALF = 2'd1;
  localparam logic [1:0] AXI_SIZE_WORD = 2'd2;

endpackage

// File: rtl/dbus_uncached_axi_bridge.sv
// Uncached/MMIO responder: turns one SRAM-like CPU request into a single-beat
// AXI read or write and returns a one-cycle completion pulse.
module dbus_uncached_axi_bridge
  import dbus_uncached_axi_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_wr,
  input  logic [1:0]            cpu_size,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [3:0]            cpu_wstrb,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_addr_ok,
  output logic                  cpu_data_ok,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arsize,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awsize,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [3:0]            wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic                  bvalid,
  output logic                  bready
);

  dbus_bridge_state_t state, state_nxt;

  logic                  req_wr;
  logic [1:0]            req_size;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [3:0]            req_wstrb;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  aw_done;
  logic                  w_done;

  logic                  accept;
  logic                  aw_fire;
  logic                  w_fire;
  logic                  r_fire;
  logic [ADDR_WIDTH-1:0] accept_addr;

  // Response codes are not reported to the core; completion is unconditional.
  logic unused_rresp;
  assign unused_rresp = ^rresp;

  assign accept  = cpu_req && cpu_addr_ok;
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign r_fire  = rready && rvalid;

  // Word accesses are always naturally aligned on the bus
  assign accept_addr = (cpu_size == AXI_SIZE_WORD) ?
                       {cpu_addr[ADDR_WIDTH-1:2], 2'b00} : cpu_addr;

  // Latched request fields drive the AXI address/data channels directly so
  // they stay stable for as long as the matching valid is held.
  assign araddr = req_addr;
  assign awaddr = req_addr;
  assign arsize = {1'b0, req_size};
  assign awsize = {1'b0, req_size};
  assign wdata  = req_wdata;
  assign wstrb  = req_wstrb;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request latch, per-channel write handshake flags and read data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      req_wr    <= 1'b0;
      req_size  <= '0;
      req_addr  <= '0;
      req_wstrb <= '0;
      req_wdata <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      if (accept) begin
        req_wr    <= cpu_wr;
        req_size  <= cpu_size;
        req_addr  <= accept_addr;
        req_wstrb <= cpu_wstrb;
        req_wdata <= cpu_wdata;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
      end else begin
        if (aw_fire) aw_done <= 1'b1;
        if (w_fire)  w_done  <= 1'b1;
      end
      if (r_fire) cpu_rdata <= rdata;
    end
  end

  // Next-state and channel controls; AW and W retire independently
  always_comb begin
    state_nxt   = state;
    cpu_addr_ok = 1'b0;
    cpu_data_ok = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    bready      = 1'b0;
    unique case (state)
      IDLE: begin
        cpu_addr_ok = 1'b1;
        if (cpu_req) state_nxt = cpu_wr ? WR_REQ : RD_ADDR;
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) state_nxt = DONE;
      end
      WR_REQ: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_nxt = DONE;
      end
      DONE: begin
        cpu_data_ok = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // req_wr is kept for debug visibility of the in-flight transaction type
  logic unused_req_wr;
  assign unused_req_wr = req_wr;

endmodule

// File: tb/tb_dbus_uncached_axi_bridge.sv
// Self-checking bench for dbus_uncached_axi_bridge: directed scenarios plus
// randomized transactions against a transaction-level reference model.
module tb_dbus_uncached_axi_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [1:0]  cpu_size = '0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]  cpu_wstrb = '0;
  logic        cpu_addr_ok, cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic [31:0] araddr, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic [3:0]  wstrb;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: last value a read returned to the core
  logic [31:0] exp_rdata = '0;

  // Request presented (held) while the previous one is still in flight
  logic        nx_wr;
  logic [1:0]  nx_size;
  logic [31:0] nx_addr, nx_wdata;
  logic [3:0]  nx_wstrb;

  dbus_uncached_axi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One CPU transaction with a slave that waits d1 (AR/AW), d2 (R/W) and d3 (B)
  // cycles of seen valid before answering. Called and returning on a negedge
  // with the bridge idle. When hold is set, the nx_* request is kept on the bus
  // for the whole transaction.
  task automatic run_txn(input logic wr, input logic [1:0] sz, input logic [31:0] ad,
                         input logic [3:0] sb, input logic [31:0] wd,
                         input int d1, input int d2, input int d3,
                         input logic [31:0] sd, input logic hold);
    logic [31:0] ea;
    int n, exp_n, c1, c2, c3;
    bit a_hs, w_hs, seen;
    ea    = (sz == 2'd2) ? {ad[31:2], 2'b00} : ad;
    exp_n = wr ? (3 + ((d1 > d2) ? d1 : d2) + d3) : (3 + d1 + d2);
    c1 = d1; c2 = d2; c3 = d3;
    a_hs = 0; w_hs = 0; seen = 0;
    chkb("addr_ok_idle", cpu_addr_ok, 1'b1);
    cpu_req = 1'b1; cpu_wr = wr; cpu_size = sz; cpu_addr = ad;
    cpu_wstrb = sb; cpu_wdata = wd;
    tick();
    if (hold) begin
      cpu_wr = nx_wr; cpu_size = nx_size; cpu_addr = nx_addr;
      cpu_wstrb = nx_wstrb; cpu_wdata = nx_wdata;
    end else begin
      cpu_req = 1'b0;
    end
    n = 1;
    while (!seen && n <= 60) begin
      arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      if (cpu_data_ok) begin
        seen = 1;
        chk("latency", 32'(n), 32'(exp_n));
        if (!wr) exp_rdata = sd;
        chk("cpu_rdata", cpu_rdata, exp_rdata);
      end else begin
        chkb("addr_ok_busy", cpu_addr_ok, 1'b0);
        if (wr) begin
          chk("rdata_hold_on_write", cpu_rdata, exp_rdata);
          if (a_hs) chkb("awvalid_dropped", awvalid, 1'b0);
          if (w_hs) chkb("wvalid_dropped", wvalid, 1'b0);
          if (awvalid) begin
            chk("awaddr", awaddr, ea);
            chk("awsize", 32'(awsize), 32'(sz));
            if (c1 == 0) begin awready = 1'b1; a_hs = 1; end else c1--;
          end
          if (wvalid) begin
            chk("wdata", wdata, wd);
            chk("wstrb", 32'(wstrb), 32'(sb));
            if (c2 == 0) begin wready = 1'b1; w_hs = 1; end else c2--;
          end
          if (bready) begin
            chkb("bready_after_aw_w", a_hs && w_hs, 1'b1);
            if (c3 == 0) bvalid = 1'b1; else c3--;
          end
        end else begin
          if (arvalid) begin
            chk("araddr", araddr, ea);
            chk("arsize", 32'(arsize), 32'(sz));
            if (c1 == 0) arready = 1'b1; else c1--;
          end
          if (rready) begin
            if (c2 == 0) begin rvalid = 1'b1; rdata = sd; end else c2--;
          end
        end
      end
      tick();
      n++;
    end
    if (!seen) chkb("data_ok_timeout", 1'b0, 1'b1);
    chkb("data_ok_one_cycle", cpu_data_ok, 1'b0);
    chkb("addr_ok_after_done", cpu_addr_ok, 1'b1);
    chk("rdata_after_done", cpu_rdata, exp_rdata);
  endtask

  initial begin
    // Reset state
    tick(); tick(); tick();
    chkb("rst_addr_ok", cpu_addr_ok, 1'b1);
    chkb("rst_data_ok", cpu_data_ok, 1'b0);
    chkb("rst_arvalid", arvalid, 1'b0);
    chkb("rst_awvalid", awvalid, 1'b0);
    chkb("rst_wvalid", wvalid, 1'b0);
    chkb("rst_rready", rready, 1'b0);
    chkb("rst_bready", bready, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    reset = 1'b0;
    tick();

    // Word read, zero-wait slave
    run_txn(1'b0, 2'd2, 32'h1FAF_0010, 4'hF, 32'h0, 0, 0, 0, 32'hDEAD_BEEF, 1'b0);
    // Byte write to the top lane
    run_txn(1'b1, 2'd0, 32'h1FAF_0003, 4'b1000, 32'hAB00_0000, 0, 0, 0, 32'h0, 1'b0);
    // Write: W accepted immediately, AW after 3 cycles, B one cycle late
    run_txn(1'b1, 2'd2, 32'h1FAF_0020, 4'hF, 32'h1234_5678, 3, 0, 1, 32'h0, 1'b0);
    // Write: AW first, W later
    run_txn(1'b1, 2'd1, 32'h1FAF_0022, 4'b1100, 32'h5A5A_0000, 0, 2, 0, 32'h0, 1'b0);
    // Slow read: AR after 4, R after 5
    run_txn(1'b0, 2'd1, 32'h1FAF_0102, 4'h0, 32'h0, 4, 5, 0, 32'hCAFE_F00D, 1'b0);
    // Unaligned word read is issued aligned
    run_txn(1'b0, 2'd2, 32'h1FAF_0013, 4'h0, 32'h0, 1, 0, 0, 32'h0BAD_C0DE, 1'b0);

    // Back-to-back: a write is held on the bus during a read
    nx_wr = 1'b1; nx_size = 2'd2; nx_addr = 32'h1FAF_0040;
    nx_wstrb = 4'hF; nx_wdata = 32'h7777_8888;
    run_txn(1'b0, 2'd2, 32'h1FAF_0030, 4'h0, 32'h0, 1, 1, 0, 32'h1357_9BDF, 1'b1);
    run_txn(1'b1, 2'd2, 32'h1FAF_0040, 4'hF, 32'h7777_8888, 1, 2, 1, 32'h0, 1'b0);

    // Randomized transactions
    for (int i = 0; i < 24; i++) begin
      logic        r_wr;
      logic [1:0]  r_sz;
      logic [31:0] r_ad, r_wd, r_sd;
      logic [3:0]  r_sb;
      r_wr = 1'($urandom_range(0, 1));
      r_sz = 2'($urandom_range(0, 2));
      r_ad = $urandom;
      r_wd = $urandom;
      r_sd = $urandom;
      r_sb = 4'($urandom_range(1, 15));
      run_txn(r_wr, r_sz, r_ad, r_sb, r_wd, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r_sd, 1'b0);
    end

    // Reset while waiting in RD_DATA
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h1FAF_0200;
    tick();
    cpu_req = 1'b0;
    chkb("rstmid_arvalid_pre", arvalid, 1'b1);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chkb("rstmid_rready_pre", rready, 1'b1);
    reset = 1'b1;
    tick();
    chkb("rstmid_arvalid", arvalid, 1'b0);
    chkb("rstmid_rready", rready, 1'b0);
    chkb("rstmid_data_ok", cpu_data_ok, 1'b0);
    chkb("rstmid_addr_ok", cpu_addr_ok, 1'b1);
    chk("rstmid_cpu_rdata", cpu_rdata, 32'h0);
    reset = 1'b0;
    exp_rdata = 32'h0;
    tick();
    // Bridge recovers and serves a normal transaction
    run_txn(1'b0, 2'd0, 32'h1FAF_0301, 4'h0, 32'h0, 0, 1, 0, 32'h0000_00A5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
